fetch_sequencer: RTL and testbench

Program-counter and fetch sequencer for the 9-bit class core. It owns the instruction address presented to the combinational instruction ROM (`InstROM`), starts execution on a `Start` pulse, and steps, branches or jumps the address each cycle. It holds the address on a stall and stops on `Halt`, raising `Done` for the testbench. It also keeps a retired-instruction counter for performance reporting.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/next_pc_sel.sv | 33 +++
 rtl/fetch_sequencer.sv | 95 +++++++++
 tb/tb_fetch_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer.
// Holds the FSM state enum and the default widths/addresses.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fetch_state_t;

  localparam int unsigned START_ADDR_DEF = 0;
  localparam int          OW_DEF         = 6;
  localparam int          INSTCOUNT_W    = 16;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-address select for the fetch sequencer.
// Hold beats jump, jump beats branch, otherwise step; wraps modulo 2**IW.
import fetch_pkg::*;

module next_pc_sel #(
  parameter int IW = 10,
  parameter int OW = OW_DEF
) (
  input  logic [IW-1:0] pc_i,
  input  logic          hold_i,
  input  logic          jmp_i,
  input  logic [IW-1:0] tgt_i,
  input  logic          br_i,
  input  logic [OW-1:0] off_i,
  output logic [IW-1:0] npc_o
);

  logic [IW-1:0] off_ext;

  assign off_ext = {{(IW-OW){off_i[OW-1]}}, off_i};

  always_comb begin
    npc_o = pc_i + IW'(1);
    if (hold_i) begin
      npc_o = pc_i;
    end else if (jmp_i) begin
      npc_o = tgt_i;
    end else if (br_i) begin
      npc_o = pc_i + off_ext;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer with start/stall/halt control
// and a saturating retired-instruction counter.
import fetch_pkg::*;

module fetch_sequencer #(
  parameter int          IW         = 10,
  parameter int          OW         = OW_DEF,
  parameter int unsigned START_ADDR = START_ADDR_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Stall,
  input  logic                   Halt,
  input  logic                   BranchRel,
  input  logic [OW-1:0]          BrOffset,
  input  logic                   JumpAbs,
  input  logic [IW-1:0]          JumpTarget,
  output logic [IW-1:0]          InstAddress,
  output logic                   InstValid,
  output logic                   Done,
  output logic [INSTCOUNT_W-1:0] InstCount
);

  localparam logic [IW-1:0] START_PC = IW'(START_ADDR);

  fetch_state_t           state_q;
  logic [IW-1:0]          pc_q;
  logic [IW-1:0]          pc_d;
  logic                   valid_q;
  logic                   done_q;
  logic [INSTCOUNT_W-1:0] cnt_q;
  logic [INSTCOUNT_W-1:0] cnt_d;

  next_pc_sel #(
    .IW(IW),
    .OW(OW)
  ) u_npc (
    .pc_i  (pc_q),
    .hold_i(Stall | Halt),
    .jmp_i (JumpAbs),
    .tgt_i (JumpTarget),
    .br_i  (BranchRel),
    .off_i (BrOffset),
    .npc_o (pc_d)
  );

  assign cnt_d = (cnt_q == '1) ? cnt_q
                               : cnt_q + INSTCOUNT_W'(1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_q <= S_RUN;
            pc_q    <= START_PC;
            valid_q <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          // A stalled cycle retires nothing and redirects nothing.
          if (!Stall) begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            if (Halt) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign InstAddress = pc_q;
  assign InstValid   = valid_q;
  assign Done        = done_q;
  assign InstCount   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table through a
// scoreboard queue, plus async-reset and counter-saturation sequences.
module tb_fetch_sequencer;

  typedef struct {
    logic        start;
    logic        stall;
    logic        halt;
    logic        br;
    logic [5:0]  off;
    logic        jmp;
    logic [9:0]  tgt;
    logic [9:0]  addr;
    logic        valid;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Stall;
  logic        Halt;
  logic        BranchRel;
  logic [5:0]  BrOffset;
  logic        JumpAbs;
  logic [9:0]  JumpTarget;
  logic [9:0]  InstAddress;
  logic        InstValid;
  logic        Done;
  logic [15:0] InstCount;

  int n_cmp;
  int n_bad;

  vec_t tbl[$];
  vec_t sb[$];

  fetch_sequencer #(
    .IW(10),
    .OW(6),
    .START_ADDR(0)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Stall      (Stall),
    .Halt       (Halt),
    .BranchRel  (BranchRel),
    .BrOffset   (BrOffset),
    .JumpAbs    (JumpAbs),
    .JumpTarget (JumpTarget),
    .InstAddress(InstAddress),
    .InstValid  (InstValid),
    .Done       (Done),
    .InstCount  (InstCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(
    input int st, input int sl, input int h,
    input int b, input int o, input int j,
    input int t, input int a, input int v,
    input int d, input int c);
    vec_t r;
    r.start = 1'(st);
    r.stall = 1'(sl);
    r.halt  = 1'(h);
    r.br    = 1'(b);
    r.off   = 6'(o);
    r.jmp   = 1'(j);
    r.tgt   = 10'(t);
    r.addr  = 10'(a);
    r.valid = 1'(v);
    r.done  = 1'(d);
    r.cnt   = 16'(c);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d expected %0d",
               nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Start      = 1'b0;
    Stall      = 1'b0;
    Halt       = 1'b0;
    BranchRel  = 1'b0;
    BrOffset   = '0;
    JumpAbs    = 1'b0;
    JumpTarget = '0;
  endtask

  task automatic chk_out(input string tag, input int idx,
                         input int a, input int v,
                         input int d, input int c);
    chk({tag, ".addr"},  idx, int'(InstAddress), a);
    chk({tag, ".valid"}, idx, int'(InstValid), v);
    chk({tag, ".done"},  idx, int'(Done), d);
    chk({tag, ".cnt"},   idx, int'(InstCount), c);
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge Clk);
    Start      = v.start;
    Stall      = v.stall;
    Halt       = v.halt;
    BranchRel  = v.br;
    BrOffset   = v.off;
    JumpAbs    = v.jmp;
    JumpTarget = v.tgt;
    sb.push_back(v);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk_out("vec", idx, int'(e.addr), int'(e.valid),
            int'(e.done), int'(e.cnt));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b0;

    //        st sl h  b  off    j  tgt   addr  v  d  cnt
    tbl.push_back(mk(0, 0, 1, 1, 4,    1, 50,   0,    0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0,    0,    1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0,    1,    1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0,    2,    1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0,    3,    1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 1023, 1023, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0,    0,    1, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0,    1,    1, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0,    2,    1, 0, 7));
    tbl.push_back(mk(0, 0, 0, 1, 'h3D, 0, 0,    1023, 1, 0, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 5,    5,    1, 0, 9));
    tbl.push_back(mk(0, 1, 1, 0, 0,    1, 50,   5,    1, 0, 9));
    tbl.push_back(mk(0, 1, 1, 0, 0,    1, 50,   5,    1, 0, 9));
    tbl.push_back(mk(0, 1, 1, 0, 0,    1, 50,   5,    1, 0, 9));
    tbl.push_back(mk(0, 0, 1, 0, 0,    0, 0,    5,    0, 1, 10));
    tbl.push_back(mk(0, 0, 1, 1, 3,    1, 60,   5,    0, 1, 10));
    tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0,    0,    1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 10,   10,   1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4,    1, 100,  100,  1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 7,    7,    1, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0,    8,    1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 1, 4,    0, 0,    12,   1, 0, 5));
    tbl.push_back(mk(0, 0, 0, 1, 'h20, 0, 0,    1004, 1, 0, 6));
    tbl.push_back(mk(0, 0, 0, 1, 'h1F, 0, 0,    11,   1, 0, 7));
    tbl.push_back(mk(1, 1, 0, 0, 0,    0, 0,    11,   1, 0, 7));
    tbl.push_back(mk(0, 0, 1, 0, 0,    0, 0,    11,   0, 1, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0,    0,    1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0,    1,    1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 300,  300,  1, 0, 2));

    foreach (tbl[i]) apply(tbl[i], i);
    chk("sb.empty", 0, sb.size(), 0);

    // Asynchronous reset between edges while running.
    @(negedge Clk);
    idle_inputs();
    #2;
    Reset = 1'b1;
    #1;
    chk_out("areset", 0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    chk_out("areset.idle", 0, 0, 0, 0, 0);

    // Run long enough to saturate the retired-instruction counter.
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk_out("sat.start", 0, 0, 1, 0, 0);
    repeat (65534) @(posedge Clk);
    #1;
    chk_out("sat.pre", 0, 65534 % 1024, 1, 0, 16'hFFFE);
    repeat (6) @(posedge Clk);
    #1;
    chk_out("sat.end", 0, 65540 % 1024, 1, 0, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
